// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing a 2:1 mux between two valid/ready requesters, with a registered output stage.
// Optional grant-entry counter on port switch_cnt when MUX2_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | no grant; picks a requester (ties go opposite last_grant)
// GNT1  | requester 0 (in1) owns the mux, sel=0
// GNT2  | requester 1 (in2) owns the mux, sel=1
module mux2_rr_arbiter #(
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   input  logic             in2_valid,
   input  logic [WIDTH-1:0] in2_data,
   output logic             in2_ready,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
`ifdef MUX2_ARB_STATS_EN
   ,
   output logic [15:0]      switch_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, GNT1, GNT2} state_t;

   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

   state_t     state, state_nxt, other_gnt;
   logic [3:0] beat_cnt, cnt_nxt;
   logic       last_grant;
   logic       slot_free, own_valid, other_valid;
   logic       xfer, grant_entry;

   assign slot_free = !out_valid || out_ready;
   assign in1_ready = (state == GNT1) && slot_free;
   assign in2_ready = (state == GNT2) && slot_free;
   assign sel       = (state == GNT2);
   assign xfer      = (in1_valid && in1_ready) || (in2_valid && in2_ready);

   assign own_valid   = (state == GNT2) ? in2_valid : in1_valid;
   assign other_valid = (state == GNT2) ? in1_valid : in2_valid;
   assign other_gnt   = (state == GNT2) ? GNT1 : GNT2;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = beat_cnt;
      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (in1_valid && (!in2_valid || last_grant))
               state_nxt = GNT1;
            else if (in2_valid)
               state_nxt = GNT2;
         end
         GNT1, GNT2: begin
            // with slot_free low everything is frozen until downstream drains
            if (slot_free) begin
               if (own_valid) begin
                  if (beat_cnt == BURST_LAST) begin
                     cnt_nxt = '0;
                     if (other_valid)
                        state_nxt = other_gnt;
                  end else begin
                     cnt_nxt = beat_cnt + 4'd1;
                  end
               end else begin
                  cnt_nxt   = '0;
                  state_nxt = other_valid ? other_gnt : IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign grant_entry = (state_nxt != state) && (state_nxt != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         beat_cnt   <= '0;
         last_grant <= 1'b1;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= grant_entry ? 4'd0 : cnt_nxt;
         if (grant_entry)
            last_grant <= (state_nxt == GNT2);
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel ? in2_data : in1_data;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef MUX2_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset)
         switch_cnt <= '0;
      else if (grant_entry && (switch_cnt != 16'hFFFF))
         switch_cnt <= switch_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: cycle vector table plus scoreboard-checked streaming sequences.
module tb_mux2_rr_arbiter;

   localparam int WIDTH = 32;
   localparam logic [31:0] DA = 32'hAAAAAAAA;
   localparam logic [31:0] D5 = 32'h55555555;

   logic             clk = 1'b0;
   logic             reset;
   logic             in1_valid, in2_valid, in1_ready, in2_ready;
   logic [WIDTH-1:0] in1_data, in2_data, out_data;
   logic             sel, out_valid, out_ready;
`ifdef MUX2_ARB_STATS_EN
   logic [15:0]      switch_cnt;
`endif

   always #5 clk = ~clk;

   mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .in2_valid (in2_valid),
      .in2_data  (in2_data),
      .in2_ready (in2_ready),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
`ifdef MUX2_ARB_STATS_EN
      ,
      .switch_cnt(switch_cnt)
`endif
   );

`ifdef MUX2_ARB_STATS_EN
   logic             reset_s;
   logic             s_r1, s_r2, s_sel, s_ov;
   logic [WIDTH-1:0] s_od;
   logic [15:0]      s_cnt;
   mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(1)) u_sat (
      .clk       (clk),
      .reset     (reset_s),
      .in1_valid (1'b1),
      .in1_data  (DA),
      .in1_ready (s_r1),
      .in2_valid (1'b1),
      .in2_data  (D5),
      .in2_ready (s_r2),
      .sel       (s_sel),
      .out_valid (s_ov),
      .out_data  (s_od),
      .out_ready (1'b1),
      .switch_cnt(s_cnt)
   );
`endif

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic        v1, v2, ordy;
      logic        r1, r2, sel, ov;
      logic [31:0] od;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] src1[$], src2[$], exp_q[$];
   int          beats, cyc, first_beat, last_beat;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic add(logic v1, logic v2, logic ordy, logic r1, logic r2,
                      logic s, logic ov, logic [31:0] od);
      vec_t v;
      v.v1 = v1; v.v2 = v2; v.ordy = ordy;
      v.r1 = r1; v.r2 = r2; v.sel = s; v.ov = ov; v.od = od;
      tbl.push_back(v);
   endtask

   task automatic present();
      in1_valid = (src1.size() != 0);
      in2_valid = (src2.size() != 0);
      if (in1_valid) in1_data = src1[0];
      if (in2_valid) in2_data = src2[0];
   endtask

   task automatic do_reset();
      reset = 1'b1;
      src1.delete(); src2.delete(); exp_q.delete();
      present();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      beats = 0; cyc = 0; first_beat = 0; last_beat = 0;
   endtask

   // one cycle: observe at negedge, let the edge happen, then advance the requesters
   task automatic tick();
      logic hs1, hs2;
      logic [31:0] e;
      @(negedge clk);
      hs1 = in1_valid && in1_ready;
      hs2 = in2_valid && in2_ready;
      check("one_ready", {31'b0, in1_ready && in2_ready}, 32'd0);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_beat actual=%h required=none", out_data);
         end else begin
            e = exp_q.pop_front();
            check("sb_data", out_data, e);
         end
         if (beats == 0) first_beat = cyc;
         last_beat = cyc;
         beats++;
      end
      cyc++;
      @(posedge clk);
      #1;
      if (hs1) void'(src1.pop_front());
      if (hs2) void'(src2.pop_front());
      present();
   endtask

   task automatic run_until(int target, int budget);
      while (beats < target && budget > 0) begin
         tick();
         budget--;
      end
      check("beats_in_budget", beats, target);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; out_ready = 1'b0;
      in1_valid = 1'b0; in2_valid = 1'b0;
      in1_data = '0; in2_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_sel", {31'b0, sel}, 32'd0);
      check("rst_in1_ready", {31'b0, in1_ready}, 32'd0);
      check("rst_in2_ready", {31'b0, in2_ready}, 32'd0);
      reset = 1'b0;

      // v1 v2 ordy | r1 r2 sel ov od
      add(0,0,1, 0,0,0,0, 32'd0);
      add(1,0,1, 0,0,0,0, 32'd0);   // solo in1: decision cycle
      add(1,0,1, 1,0,0,0, 32'd0);   // ready one cycle after valid
      add(0,0,1, 1,0,0,1, DA);      // beat out two cycles after valid
      add(0,0,1, 0,0,0,0, DA);
      add(0,1,1, 0,0,0,0, DA);      // solo in2
      add(0,1,1, 0,1,1,0, DA);
      add(0,0,1, 0,1,1,1, D5);
      add(0,0,1, 0,0,0,0, D5);
      add(0,1,1, 0,0,0,0, D5);      // early release after 2 beats
      add(0,1,1, 0,1,1,0, D5);
      add(0,1,1, 0,1,1,1, D5);
      add(0,0,1, 0,1,1,1, D5);
      add(0,0,1, 0,0,0,0, D5);      // back to IDLE, sel=0
      add(0,1,1, 0,0,0,0, D5);      // later in2-only request re-grants GNT2
      add(0,1,1, 0,1,1,0, D5);
      add(0,0,1, 0,1,1,1, D5);
      add(0,0,1, 0,0,0,0, D5);
      add(1,0,1, 0,0,0,0, D5);      // grant held while backpressured with valid low
      add(1,0,0, 1,0,0,0, D5);
      add(0,0,0, 0,0,0,1, DA);
      add(0,0,0, 0,0,0,1, DA);
      add(0,0,1, 1,0,0,1, DA);
      add(0,0,1, 0,0,0,0, DA);

      in1_data = DA; in2_data = D5;
      foreach (tbl[i]) begin
         in1_valid = tbl[i].v1;
         in2_valid = tbl[i].v2;
         out_ready = tbl[i].ordy;
         @(negedge clk);
         check($sformatf("vec%0d_in1_ready", i), {31'b0, in1_ready}, {31'b0, tbl[i].r1});
         check($sformatf("vec%0d_in2_ready", i), {31'b0, in2_ready}, {31'b0, tbl[i].r2});
         check($sformatf("vec%0d_sel", i), {31'b0, sel}, {31'b0, tbl[i].sel});
         check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
         check($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
         @(posedge clk);
         #1;
      end

      // tie, round-robin with bursts of 4 and no idle gap
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) src1.push_back(32'hAAAA_0000 + i);
      for (int i = 0; i < 4; i++) src2.push_back(32'h5555_0000 + i);
      for (int i = 0; i < 4; i++) exp_q.push_back(32'hAAAA_0000 + i);
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h5555_0000 + i);
      for (int i = 4; i < 8; i++) exp_q.push_back(32'hAAAA_0000 + i);
      present();
      run_until(12, 60);
      check("tie_span", last_beat - first_beat + 1, 32'd12);
      check("tie_sb_left", exp_q.size(), 32'd0);
      check("tie_end_out_valid", {31'b0, out_valid}, 32'd0);
      check("tie_end_sel", {31'b0, sel}, 32'd0);
`ifdef MUX2_ARB_STATS_EN
      check("tie_switch_cnt", {16'b0, switch_cnt}, 32'd3);
`endif

      // backpressure mid-burst for 5 cycles
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) src1.push_back(32'hA1A1_0000 + i);
      for (int i = 0; i < 4; i++) src2.push_back(32'h5151_0000 + i);
      for (int i = 0; i < 4; i++) exp_q.push_back(32'hA1A1_0000 + i);
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h5151_0000 + i);
      for (int i = 4; i < 8; i++) exp_q.push_back(32'hA1A1_0000 + i);
      present();
      run_until(2, 20);
      out_ready = 1'b0;
      repeat (5) begin
         tick();
         check("bp_out_valid", {31'b0, out_valid}, 32'd1);
         check("bp_out_data", out_data, exp_q[0]);
         check("bp_in1_ready", {31'b0, in1_ready}, 32'd0);
         check("bp_in2_ready", {31'b0, in2_ready}, 32'd0);
      end
      out_ready = 1'b1;
      run_until(12, 60);
      check("bp_sb_left", exp_q.size(), 32'd0);
      tick(); tick();
      check("bp_beats_total", beats, 32'd12);

      // reset mid-burst, then a tie grants requester 0
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) src1.push_back(32'hC0C0_0000 + i);
      exp_q.push_back(32'hC0C0_0000);
      present();
      run_until(1, 20);
      check("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_in1_ready", {31'b0, in1_ready}, 32'd0);
      check("mid_rst_sel", {31'b0, sel}, 32'd0);
      src1.delete(); src2.delete(); exp_q.delete();
      beats = 0; cyc = 0;
      reset = 1'b0;
      for (int i = 0; i < 2; i++) src1.push_back(32'hC1C1_0000 + i);
      for (int i = 0; i < 2; i++) src2.push_back(32'hD1D1_0000 + i);
      for (int i = 0; i < 2; i++) exp_q.push_back(32'hC1C1_0000 + i);
      for (int i = 0; i < 2; i++) exp_q.push_back(32'hD1D1_0000 + i);
      present();
      run_until(4, 30);
      check("post_rst_sb_left", exp_q.size(), 32'd0);

`ifdef MUX2_ARB_STATS_EN
      reset_s = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("sat_reset", {16'b0, s_cnt}, 32'd0);
      reset_s = 1'b0;
      repeat (65545) @(posedge clk);
      #1;
      check("sat_switch_cnt", {16'b0, s_cnt}, 32'h0000FFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
